// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a two-port writeback,
// a per-register pending-write scoreboard and a sequenced clear engine.
// Register 0 is hardwired to zero.
// Optional build macro REGFILE_MP_BYPASS_EN: same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic              w0_en_i,
  input  logic [AW-1:0]     w0_addr_i,
  input  logic [XLEN-1:0]   w0_data_i,
  input  logic              w1_en_i,
  input  logic [AW-1:0]     w1_addr_i,
  input  logic [XLEN-1:0]   w1_data_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   sweepIdx_q, sweepIdx_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic idle;
  logic w0Ok;
  logic w1Ok;
  logic issOk;

  // Writes and issues only take effect while the clear engine is idle;
  // address 0 is never a legal destination.
  assign idle  = (state_q == IDLE);
  assign w0Ok  = idle && w0_en_i && (w0_addr_i != '0);
  assign w1Ok  = idle && w1_en_i && (w1_addr_i != '0);
  assign issOk = idle && iss_en_i && (iss_addr_i != '0);

  assign clr_busy_o = (state_q == SWEEP);
  assign clr_done_o = done_q;

  // Clear engine state, sweep index and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sweepIdx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweepIdx_q <= sweepIdx_d;
      done_q     <= done_d;
    end
  end

  // Sweep sequencing: start at register 1, leave after the last register;
  // the index naturally wraps back to 0 as the sweep ends.
  always_comb begin
    state_d    = state_q;
    sweepIdx_d = sweepIdx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d    = SWEEP;
          sweepIdx_d = AW'(1);
        end
      end
      SWEEP: begin
        sweepIdx_d = sweepIdx_q + AW'(1);
        if (sweepIdx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register array: sweep zeroes one entry per cycle, otherwise writeback;
  // port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      regs_q[sweepIdx_q] <= '0;
    end else begin
      if (w0Ok) begin
        regs_q[w0_addr_i] <= w0_data_i;
      end
      if (w1Ok) begin
        regs_q[w1_addr_i] <= w1_data_i;
      end
    end
  end

  // Scoreboard next state: writeback clears first, then issue sets, so an
  // issue landing together with a writeback to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (idle) begin
      if (clr_req_i) begin
        busy_d = '0;
      end else begin
        for (int r = 1; r < NREG; r++) begin
          if ((w0Ok && (w0_addr_i == AW'(r))) || (w1Ok && (w1_addr_i == AW'(r)))) begin
            busy_d[r] = 1'b0;
          end
          if (issOk && (iss_addr_i == AW'(r))) begin
            busy_d[r] = 1'b1;
          end
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; register 0 always reads zero and never busy.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_addr_i[k*AW +: AW] != '0) begin
        rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
        rd_busy_o[k]              = busy_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        if (w1Ok && (w1_addr_i == rd_addr_i[k*AW +: AW])) begin
          rd_data_o[k*XLEN +: XLEN] = w1_data_i;
          rd_busy_o[k]              = 1'b0;
        end else if (w0Ok && (w0_addr_i == rd_addr_i[k*AW +: AW])) begin
          rd_data_o[k*XLEN +: XLEN] = w0_data_i;
          rd_busy_o[k]              = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 w0_en, w1_en, iss_en, clr_req;
  logic [AW-1:0]        w0_addr, w1_addr, iss_addr;
  logic [XLEN-1:0]      w0_data, w1_data;
  logic                 clr_busy, clr_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] d;
  logic            b;
  int              len;
  int              dones;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .w0_en_i    (w0_en),
    .w0_addr_i  (w0_addr),
    .w0_data_i  (w0_data),
    .w1_en_i    (w1_en),
    .w1_addr_i  (w1_addr),
    .w1_data_i  (w1_data),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    w0_en   = 1'b0;
    w1_en   = 1'b0;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                               input logic ie, input logic [AW-1:0] ia, input logic cr);
    w0_en    = e0;
    w0_addr  = a0;
    w0_data  = d0;
    w1_en    = e1;
    w1_addr  = a1;
    w1_data  = d1;
    iss_en   = ie;
    iss_addr = ia;
    clr_req  = cr;
  endtask

  task automatic readPort(input int port, input logic [AW-1:0] a,
                          output logic [XLEN-1:0] data, output logic busy);
    rd_addr[port*AW +: AW] = a;
    #1;
    data = rd_data[port*XLEN +: XLEN];
    busy = rd_busy[port];
  endtask

  task automatic checkAllZero(input string tag);
    logic [XLEN-1:0] rd;
    logic            rb;
    for (int a = 0; a < NREG; a++) begin
      for (int p = 0; p < NRD; p++) begin
        readPort(p, AW'(a), rd, rb);
        checkOutput($sformatf("%s_data_x%0d_p%0d", tag, a, p), rd, 32'h0);
        checkOutput($sformatf("%s_busy_x%0d_p%0d", tag, a, p), 32'(rb), 32'h0);
      end
    end
  endtask

  // Pulse clr_req, then count busy cycles and done pulses; a write to x3
  // and an issue to x20 are injected mid-sweep and must be ignored.
  task automatic runSweep(output int sweepLen, output int donePulses);
    sweepLen   = 0;
    donePulses = 0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    cycle();
    idleInputs();
    while (clr_busy && (sweepLen < 100)) begin
      sweepLen++;
      if (clr_done) donePulses++;
      if (sweepLen == 10) begin
        applyStimulus(1'b1, 5'd3, 32'h00000BAD, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0);
      end else begin
        idleInputs();
      end
      cycle();
    end
    idleInputs();
    checkOutput("sweep_doneFirstIdle", 32'(clr_done), 32'h1);
    if (clr_done) donePulses++;
    cycle();
    checkOutput("sweep_doneDrops", 32'(clr_done), 32'h0);
    if (clr_done) donePulses++;
  endtask

  initial begin
    rd_addr  = '0;
    w0_addr  = '0;
    w1_addr  = '0;
    iss_addr = '0;
    w0_data  = '0;
    w1_data  = '0;
    idleInputs();

    // Reset state
    #1;
    checkOutput("rst_clrBusy", 32'(clr_busy), 32'h0);
    checkOutput("rst_clrDone", 32'(clr_done), 32'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    cycle();
    checkAllZero("afterReset");
    checkOutput("afterReset_clrBusy", 32'(clr_busy), 32'h0);
    cycle();

    // Write collision: port 1 wins; x0 discards writes
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0);
    cycle();
    idleInputs();
    readPort(0, 5'd5, d, b);
    checkOutput("x5_port1Wins", d, 32'h12345678);
    cycle();
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle();
    idleInputs();
    readPort(0, 5'd0, d, b);
    checkOutput("x0_p0_zero", d, 32'h0);
    readPort(1, 5'd0, d, b);
    checkOutput("x0_p1_zero", d, 32'h0);
    cycle();

    // Scoreboard: issue sets, issue+writeback stays busy, writeback clears
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    cycle();
    idleInputs();
    readPort(1, 5'd7, d, b);
    checkOutput("x7_busyAfterIssue", 32'(b), 32'h1);
    cycle();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    cycle();
    idleInputs();
    readPort(0, 5'd7, d, b);
    checkOutput("x7_busyIssueAndWb", 32'(b), 32'h1);
    checkOutput("x7_dataW0", d, 32'hA5A5A5A5);
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h5A5A0001, 1'b0, 5'd0, 1'b0);
    cycle();
    idleInputs();
    readPort(1, 5'd7, d, b);
    checkOutput("x7_busyCleared", 32'(b), 32'h0);
    checkOutput("x7_dataW1", d, 32'h5A5A0001);
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    cycle();
    idleInputs();
    readPort(0, 5'd0, d, b);
    checkOutput("x0_issueIgnored", 32'(b), 32'h0);
    cycle();

    // Same-cycle read of a register being written
    applyStimulus(1'b1, 5'd9, 32'h11112222, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    cycle();
    idleInputs();
    readPort(1, 5'd9, d, b);
    checkOutput("x9_initData", d, 32'h11112222);
    checkOutput("x9_initBusy", 32'(b), 32'h1);
    cycle();
    applyStimulus(1'b1, 5'd9, 32'h0000CAFE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    readPort(1, 5'd9, d, b);
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("x9_sameCycleData", d, 32'h0000CAFE);
    checkOutput("x9_sameCycleBusy", 32'(b), 32'h0);
`else
    checkOutput("x9_sameCycleData", d, 32'h11112222);
    checkOutput("x9_sameCycleBusy", 32'(b), 32'h1);
`endif
    cycle();
    idleInputs();
    readPort(1, 5'd9, d, b);
    checkOutput("x9_nextCycleData", d, 32'h0000CAFE);
    checkOutput("x9_nextCycleBusy", 32'(b), 32'h0);
    cycle();

    // Fill x1..x31 with their index (x12 also issued), then full sweep
    for (int i = 1; i < NREG; i++) begin
      applyStimulus(1'b1, AW'(i), XLEN'(i), 1'b0, 5'd0, 32'h0, (i == 12), 5'd12, 1'b0);
      cycle();
    end
    idleInputs();
    readPort(0, 5'd30, d, b);
    checkOutput("fill_x30", d, 32'd30);
    readPort(1, 5'd12, d, b);
    checkOutput("fill_x12Busy", 32'(b), 32'h1);
    cycle();
    runSweep(len, dones);
    checkOutput("sweep1_len", XLEN'(len), 32'd31);
    checkOutput("sweep1_donePulses", XLEN'(dones), 32'd1);
    cycle();
    checkAllZero("afterSweep");
    cycle();

    // Reset during sweep cycle 10 aborts without a done pulse
    applyStimulus(1'b1, 5'd20, 32'h00000020, 1'b1, 5'd31, 32'h00000031, 1'b0, 5'd0, 1'b0);
    cycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    cycle();
    idleInputs();
    repeat (9) cycle();
    checkOutput("abort_busyBefore", 32'(clr_busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("abort_clrBusyAsync", 32'(clr_busy), 32'h0);
    checkOutput("abort_clrDone", 32'(clr_done), 32'h0);
    readPort(0, 5'd20, d, b);
    checkOutput("abort_x20", d, 32'h0);
    readPort(1, 5'd31, d, b);
    checkOutput("abort_x31", d, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput($sformatf("abort_noDone%0d", i), 32'(clr_done), 32'h0);
      checkOutput($sformatf("abort_idle%0d", i), 32'(clr_busy), 32'h0);
    end
    runSweep(len, dones);
    checkOutput("sweep2_len", XLEN'(len), 32'd31);
    checkOutput("sweep2_donePulses", XLEN'(dones), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
